// File: rtl/laundry_pkg.sv
// rtl/laundry_pkg.sv - laundry sequencer state codes and phase helpers
package laundry_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    WAIT_WASHER = 4'd1,
    FILL        = 4'd2,
    WASH        = 4'd3,
    RINSE       = 4'd4,
    DRAIN       = 4'd5,
    WASHER_DONE = 4'd6,
    WAIT_DRYER  = 4'd7,
    HEAT        = 4'd8,
    TUMBLE      = 4'd9,
    COOL        = 4'd10,
    DRYER_DONE  = 4'd11,
    DONE        = 4'd12
  } state_e;

  localparam int unsigned NUM_TIMED = 7;

  function automatic logic is_timed(state_e s);
    return s inside {FILL, WASH, RINSE, DRAIN, HEAT, TUMBLE, COOL};
  endfunction

  function automatic logic is_washer_phase(state_e s);
    return s inside {FILL, WASH, RINSE, DRAIN};
  endfunction

  // Index into the duration table; NUM_TIMED marks an untimed state.
  function automatic logic [2:0] phase_index(state_e s);
    case (s)
      FILL:    return 3'd0;
      WASH:    return 3'd1;
      RINSE:   return 3'd2;
      DRAIN:   return 3'd3;
      HEAT:    return 3'd4;
      TUMBLE:  return 3'd5;
      COOL:    return 3'd6;
      default: return 3'(NUM_TIMED);
    endcase
  endfunction

endpackage

// File: rtl/laundry_sequencer_if.sv
// rtl/laundry_sequencer_if.sv - front-panel / actuator-side signals of the laundry sequencer
interface laundry_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             abort;
  logic             washer_door;
  logic             dryer_door;
  logic             busy;
  logic             washer_done;
  logic             dryer_done;
  logic             done;
  logic [3:0]       phase;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, abort, washer_door, dryer_door,
    input  busy, washer_done, dryer_done, done, phase, remaining
  );

  modport slave (
    input  start, abort, washer_door, dryer_door,
    output busy, washer_done, dryer_done, done, phase, remaining
  );
endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter timing one laundry phase
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/laundry_sequencer.sv
// rtl/laundry_sequencer.sv - timed washer/dryer cycle controller with door pause and abort
// Optional rinse phase between WASH and DRAIN enabled by defining LAUNDRY_RINSE_EN.
module laundry_sequencer
  import laundry_pkg::*;
#(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned FILL_CYCLES   = 4,
  parameter int unsigned WASH_CYCLES   = 8,
  parameter int unsigned RINSE_CYCLES  = 4,
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned HEAT_CYCLES   = 8,
  parameter int unsigned TUMBLE_CYCLES = 8,
  parameter int unsigned COOL_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  laundry_sequencer_if.slave bus
);

  localparam int unsigned DUR [8] = '{FILL_CYCLES, WASH_CYCLES, RINSE_CYCLES, DRAIN_CYCLES,
                                      HEAT_CYCLES, TUMBLE_CYCLES, COOL_CYCLES, 1};

  state_e           state;
  state_e           state_nxt;
  logic             paused;
  logic             t_load;
  logic             t_en;
  logic             t_clear;
  logic [CNT_W-1:0] t_load_val;
  logic [CNT_W-1:0] t_count;
  logic             t_zero;
  logic             expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    t_load     = 1'b0;
    t_load_val = '0;
    t_en       = 1'b0;
    t_clear    = 1'b0;
    paused     = is_timed(state) &&
                 (is_washer_phase(state) ? !bus.washer_door : !bus.dryer_door);
    expire     = !paused && t_zero;

    case (state)
      IDLE:        if (bus.start) state_nxt = WAIT_WASHER;
      WAIT_WASHER: if (bus.washer_door) state_nxt = FILL;
      FILL:        if (expire) state_nxt = WASH;
`ifdef LAUNDRY_RINSE_EN
      WASH:        if (expire) state_nxt = RINSE;
`else
      WASH:        if (expire) state_nxt = DRAIN;
`endif
      RINSE:       if (expire) state_nxt = DRAIN;
      DRAIN:       if (expire) state_nxt = WASHER_DONE;
      WASHER_DONE: state_nxt = WAIT_DRYER;
      WAIT_DRYER:  if (bus.dryer_door) state_nxt = HEAT;
      HEAT:        if (expire) state_nxt = TUMBLE;
      TUMBLE:      if (expire) state_nxt = COOL;
      COOL:        if (expire) state_nxt = DRYER_DONE;
      DRYER_DONE:  state_nxt = DONE;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase

    // Abort outranks everything except a start taken from IDLE.
    if (bus.abort && state != IDLE) begin
      state_nxt = IDLE;
    end

    if (state_nxt != state) begin
      if (is_timed(state_nxt)) begin
        t_load     = 1'b1;
        t_load_val = CNT_W'(DUR[phase_index(state_nxt)] - 1);
      end else begin
        t_clear = 1'b1;
      end
    end else begin
      t_en = is_timed(state) && !paused;
    end
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_load_val),
    .en       (t_en),
    .clear    (t_clear),
    .count    (t_count),
    .zero     (t_zero)
  );

  assign bus.busy        = (state != IDLE);
  assign bus.washer_done = (state == WASHER_DONE);
  assign bus.dryer_done  = (state == DRYER_DONE);
  assign bus.done        = (state == DONE);
  assign bus.phase       = state;
  assign bus.remaining   = is_timed(state) ? t_count : '0;

endmodule

// File: tb/tb_laundry_sequencer.sv
// tb/tb_laundry_sequencer.sv - directed and random checks of laundry_sequencer against a phase-plan model
module tb_laundry_sequencer;

  localparam int CNT_W    = 8;
  localparam int P_FILL   = 4;
  localparam int P_WASH   = 8;
  localparam int P_RINSE  = 4;
  localparam int P_DRAIN  = 4;
  localparam int P_HEAT   = 8;
  localparam int P_TUMBLE = 8;
  localparam int P_COOL   = 4;
`ifdef LAUNDRY_RINSE_EN
  localparam int EXTRA    = P_RINSE;
`else
  localparam int EXTRA    = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  laundry_sequencer_if #(.CNT_W(CNT_W)) bus ();

  laundry_sequencer #(
    .CNT_W(CNT_W), .FILL_CYCLES(P_FILL), .WASH_CYCLES(P_WASH), .RINSE_CYCLES(P_RINSE),
    .DRAIN_CYCLES(P_DRAIN), .HEAT_CYCLES(P_HEAT), .TUMBLE_CYCLES(P_TUMBLE), .COOL_CYCLES(P_COOL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: a run is a queue of steps; door 1=washer, 2=dryer; len 0 = untimed.
  typedef struct { int code; int len; int door; } step_t;
  step_t plan[$];
  step_t cur;
  int    m_left;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    wd_cyc, dd_cyc, dn_cyc;

  function automatic step_t mk(int c, int l, int d);
    step_t s;
    s.code = c; s.len = l; s.door = d;
    return s;
  endfunction

  task automatic build_plan();
    plan.delete();
    plan.push_back(mk(1, 0, 1));
    plan.push_back(mk(2, P_FILL, 1));
    plan.push_back(mk(3, P_WASH, 1));
`ifdef LAUNDRY_RINSE_EN
    plan.push_back(mk(4, P_RINSE, 1));
`endif
    plan.push_back(mk(5, P_DRAIN, 1));
    plan.push_back(mk(6, 0, 0));
    plan.push_back(mk(7, 0, 2));
    plan.push_back(mk(8, P_HEAT, 2));
    plan.push_back(mk(9, P_TUMBLE, 2));
    plan.push_back(mk(10, P_COOL, 2));
    plan.push_back(mk(11, 0, 0));
    plan.push_back(mk(12, 0, 0));
  endtask

  task automatic m_enter();
    if (plan.size() == 0) cur = mk(0, 0, 0);
    else cur = plan.pop_front();
    m_left = cur.len;
  endtask

  task automatic m_reset();
    plan.delete();
    cur = mk(0, 0, 0);
    m_left = 0;
  endtask

  task automatic m_edge();
    logic closed;
    if (rst_n) begin
      closed = (cur.door == 1) ? bus.washer_door : (cur.door == 2) ? bus.dryer_door : 1'b1;
      if (cur.code == 0) begin
        if (bus.start) begin
          build_plan();
          m_enter();
        end
      end else if (bus.abort) begin
        m_reset();
      end else if (cur.len == 0) begin
        if (closed) m_enter();
      end else if (closed) begin
        if (m_left == 1) m_enter();
        else m_left--;
      end
    end
  endtask

  task automatic cmp(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    cmp({tag, ".busy"},   32'(bus.busy),        32'(cur.code != 0));
    cmp({tag, ".wdone"},  32'(bus.washer_done), 32'(cur.code == 6));
    cmp({tag, ".ddone"},  32'(bus.dryer_done),  32'(cur.code == 11));
    cmp({tag, ".done"},   32'(bus.done),        32'(cur.code == 12));
    cmp({tag, ".phase"},  32'(bus.phase),       32'(cur.code));
    cmp({tag, ".remain"}, 32'(bus.remaining),   32'((cur.len > 0) ? m_left - 1 : 0));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    m_edge();
    cyc++;
    #1;
    check_all(tag);
  endtask

  task automatic run_to_idle(string tag);
    for (int i = 0; i < 300 && bus.busy === 1'b1; i++) tick(tag);
    cmp({tag, ".idle_reached"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.washer_door = 1'b1;
    bus.dryer_door = 1'b1;
    m_reset();

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    cmp("reset.phase_const", 32'(bus.phase), 32'd0);
    rst_n = 1'b1;
    tick("idle");

    // Nominal run with timeline landmarks.
    cyc = 0; wd_cyc = -1; dd_cyc = -1; dn_cyc = -1;
    bus.start = 1'b1;
    tick("nom");
    bus.start = 1'b0;
    for (int i = 0; i < 100 && bus.busy === 1'b1; i++) begin
      tick("nom");
      if (bus.washer_done === 1'b1 && wd_cyc < 0) wd_cyc = cyc;
      if (bus.dryer_done === 1'b1 && dd_cyc < 0) dd_cyc = cyc;
      if (bus.done === 1'b1 && dn_cyc < 0) dn_cyc = cyc;
    end
    cmp("nom.washer_done_cyc", 32'(wd_cyc), 32'(18 + EXTRA));
    cmp("nom.dryer_done_cyc",  32'(dd_cyc), 32'(40 + EXTRA));
    cmp("nom.done_cyc",        32'(dn_cyc), 32'(41 + EXTRA));
    cmp("nom.idle_cyc",        32'(cyc),    32'(42 + EXTRA));

    // Washer door opened for 3 cycles in WASH at remaining=5.
    cyc = 0; wd_cyc = -1;
    bus.start = 1'b1;
    tick("pause");
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !(bus.phase === 4'd3 && bus.remaining === 8'd5); i++) tick("pause");
    cmp("pause.reach_rem5", 32'(cyc), 32'd8);
    bus.washer_door = 1'b0;
    repeat (3) begin
      tick("pause.hold");
      cmp("pause.rem_frozen", 32'(bus.remaining), 32'd5);
    end
    bus.washer_door = 1'b1;
    for (int i = 0; i < 60 && bus.washer_done !== 1'b1; i++) tick("pause");
    cmp("pause.washer_done_cyc", 32'(cyc), 32'(21 + EXTRA));
    run_to_idle("pause");

    // Abort in TUMBLE, then restart; also start+abort together in IDLE.
    bus.start = 1'b1;
    tick("abort");
    bus.start = 1'b0;
    for (int i = 0; i < 80 && bus.phase !== 4'd9; i++) tick("abort");
    bus.abort = 1'b1;
    tick("abort.hit");
    cmp("abort.phase", 32'(bus.phase), 32'd0);
    cmp("abort.remaining", 32'(bus.remaining), 32'd0);
    bus.start = 1'b1;
    tick("abort.start_and_abort");
    cmp("abort.start_wins_in_idle", 32'(bus.phase), 32'd1);
    bus.start = 1'b0;
    tick("abort.in_wait");
    bus.abort = 1'b0;
    bus.start = 1'b1;
    tick("abort.restart");
    bus.start = 1'b0;
    cmp("abort.restart_phase", 32'(bus.phase), 32'd1);
    run_to_idle("abort");

    // Start with washer door open for 10 cycles.
    bus.washer_door = 1'b0;
    bus.start = 1'b1;
    tick("door");
    bus.start = 1'b0;
    repeat (9) tick("door.wait");
    cmp("door.still_waiting", 32'(bus.phase), 32'd1);
    bus.washer_door = 1'b1;
    tick("door.closed");
    cmp("door.fill_next", 32'(bus.phase), 32'd2);
    run_to_idle("door");

    // Asynchronous reset during DRAIN; starts while busy are ignored.
    bus.start = 1'b1;
    tick("rst");
    bus.start = 1'b0;
    for (int i = 0; i < 60 && bus.phase !== 4'd5; i++) tick("rst");
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all("rst.async");
    cmp("rst.remaining_zero", 32'(bus.remaining), 32'd0);
    tick("rst.held");
    rst_n = 1'b1;
    bus.start = 1'b1;
    tick("rst.restart");
    for (int i = 0; i < 10; i++) begin
      bus.start = (i % 2 == 0);
      tick("rst.start_ignored");
    end
    bus.start = 1'b0;
    run_to_idle("rst");

    // Random traffic.
    for (int i = 0; i < 1000; i++) begin
      bus.start = ($urandom % 6) == 0;
      bus.abort = ($urandom % 60) == 0;
      bus.washer_door = ($urandom % 6) != 0;
      bus.dryer_door = ($urandom % 6) != 0;
      tick("rand");
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.washer_door = 1'b1;
    bus.dryer_door = 1'b1;
    run_to_idle("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
